// File: rtl/cache_line_xfer.sv
// cache_line_xfer
// Purpose : single-outstanding miss handler; optional dirty-victim writeback burst, then refill burst
//           through the bus controller's shared 512-bit line FIFO.
// Latency : clean miss with an immediately responding controller -> resp_valid 12 cycles after accept.
// Backpressure: req_ready only in IDLE; the refilled line is held on resp_valid/resp_data until resp_ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset (shared with the bus controller)
//   req_*                    miss request: line address, dirty flag, victim address and victim line
//   resp_valid/ready/data    refilled 512-bit line back to the cache
//   busy                     high whenever a miss is in flight
//   ctl_*                    burst request to the bus controller (len fixed at 7, data tied 0)
//   fifo_*                   beat access into the controller's line FIFO, plus the release pulse
//   perf_*                   refill / writeback / busy-cycle counters
//
// Build option: define LINE_XFER_PERF_EN to build the perf_* counters; otherwise they are tied to 0.

module cache_line_xfer #(
   parameter int LINE_BEATS = 8,
   parameter int ADDR_W     = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [ADDR_W-1:0]        req_addr,
   input  logic                     req_dirty,
   input  logic [ADDR_W-1:0]        req_victim_addr,
   input  logic [LINE_BEATS*64-1:0] req_victim_data,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [LINE_BEATS*64-1:0] resp_data,
   output logic                     busy,
   input  logic                     ctl_ready,
   output logic                     ctl_req,
   output logic                     ctl_rw,
   output logic [ADDR_W-1:0]        ctl_addr,
   output logic [63:0]              ctl_data,
   output logic [7:0]               ctl_len,
   input  logic                     ctl_done,
   output logic [8:0]               fifo_idx,
   output logic [63:0]              fifo_wdata,
   output logic                     fifo_wen,
   output logic                     fifo_done,
   input  logic [63:0]              fifo_rdata,
   output logic [31:0]              perf_refills,
   output logic [31:0]              perf_writebacks,
   output logic [31:0]              perf_busy_cycles
);

   localparam int LINE_W = LINE_BEATS * 64;
   localparam int BEAT_W = $clog2(LINE_BEATS);
   localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(LINE_BEATS - 1);
   // Line offset bits; cleared on every captured address so bursts are line aligned.
   localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(63);

   typedef enum logic [3:0] {
      S_IDLE,
      S_W_ISSUE,
      S_W_FILL,
      S_W_WAIT,
      S_WB_REL,
      S_R_ISSUE,
      S_R_WAIT,
      S_R_DRAIN,
      S_RD_REL,
      S_RESP
   } state_t;

   state_t              state;
   state_t              state_nx;

   logic [ADDR_W-1:0]   miss_addr;
   logic [ADDR_W-1:0]   victim_addr;
   logic [LINE_W-1:0]   victim_data;
   logic [LINE_W-1:0]   line_buf;
   logic [BEAT_W-1:0]   beat;
   logic [BEAT_W+5:0]   beat_off;

   // Bit offset of the current beat, both into the controller FIFO and into the line buffers.
   assign beat_off = {beat, 6'b0};

   assign ctl_data = '0;
   assign ctl_len  = 8'(LINE_BEATS - 1);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ------------------------------------------------------------------
   // Next state and outputs (outputs are a pure function of state so
   // every output settles to its idle value one cycle after reset)
   // ------------------------------------------------------------------
   always_comb begin
      state_nx   = state;
      req_ready  = 1'b0;
      busy       = 1'b1;
      resp_valid = 1'b0;
      resp_data  = '0;
      ctl_req    = 1'b0;
      ctl_rw     = 1'b0;
      ctl_addr   = '0;
      fifo_idx   = '0;
      fifo_wdata = '0;
      fifo_wen   = 1'b0;
      fifo_done  = 1'b0;

      unique case (state)
         S_IDLE: begin
            busy      = 1'b0;
            req_ready = 1'b1;
            if (req_valid) begin
               state_nx = req_dirty ? S_W_ISSUE : S_R_ISSUE;
            end
         end

         // Controller signals acceptance by dropping ctl_ready.
         S_W_ISSUE: begin
            ctl_req  = 1'b1;
            ctl_rw   = 1'b1;
            ctl_addr = victim_addr;
            if (!ctl_ready) begin
               state_nx = S_W_FILL;
            end
         end

         // One victim beat per cycle; the controller FIFO never stalls writes.
         S_W_FILL: begin
            ctl_req    = 1'b1;
            ctl_rw     = 1'b1;
            ctl_addr   = victim_addr;
            fifo_wen   = 1'b1;
            fifo_idx   = beat_off;
            fifo_wdata = victim_data[beat_off +: 64];
            if (beat == LAST_BEAT) begin
               state_nx = S_W_WAIT;
            end
         end

         // ctl_done is sampled from the first cycle here, so a done that
         // coincides with state entry is not lost.
         S_W_WAIT: begin
            ctl_req  = 1'b1;
            ctl_rw   = 1'b1;
            ctl_addr = victim_addr;
            if (ctl_done) begin
               state_nx = S_WB_REL;
            end
         end

         S_WB_REL: begin
            fifo_done = 1'b1;
            state_nx  = S_R_ISSUE;
         end

         S_R_ISSUE: begin
            ctl_req  = 1'b1;
            ctl_addr = miss_addr;
            if (!ctl_ready) begin
               state_nx = S_R_WAIT;
            end
         end

         S_R_WAIT: begin
            ctl_req  = 1'b1;
            ctl_addr = miss_addr;
            if (ctl_done) begin
               state_nx = S_R_DRAIN;
            end
         end

         // fifo_rdata is a combinational read at fifo_idx; captured below.
         S_R_DRAIN: begin
            ctl_req  = 1'b1;
            ctl_addr = miss_addr;
            fifo_idx = beat_off;
            if (beat == LAST_BEAT) begin
               state_nx = S_RD_REL;
            end
         end

         S_RD_REL: begin
            fifo_done = 1'b1;
            state_nx  = S_RESP;
         end

         // Leaving on the handshake cycle means req_ready is low in that
         // cycle; the next miss is taken from IDLE one cycle later.
         S_RESP: begin
            resp_valid = 1'b1;
            resp_data  = line_buf;
            if (resp_ready) begin
               state_nx = S_IDLE;
            end
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Request capture, beat counter and refill line assembly
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         miss_addr   <= '0;
         victim_addr <= '0;
         victim_data <= '0;
         line_buf    <= '0;
         beat        <= '0;
      end else begin
         if (state == S_IDLE && req_valid) begin
            miss_addr   <= req_addr & ~OFFSET_MASK;
            victim_addr <= req_victim_addr & ~OFFSET_MASK;
            victim_data <= req_victim_data;
         end

         // Counter wraps back to 0 after the last beat, ready for the next burst.
         if (state == S_W_FILL || state == S_R_DRAIN) begin
            beat <= beat + 1'b1;
         end

         if (state == S_R_DRAIN) begin
            line_buf[beat_off +: 64] <= fifo_rdata;
         end
      end
   end

   // ------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------
`ifdef LINE_XFER_PERF_EN
   logic [31:0] refills_q;
   logic [31:0] writebacks_q;
   logic [31:0] busy_cycles_q;

   // Plain 32-bit adders: counters wrap from all-ones back to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         refills_q     <= '0;
         writebacks_q  <= '0;
         busy_cycles_q <= '0;
      end else begin
         if (state == S_RD_REL) begin
            refills_q <= refills_q + 32'd1;
         end
         if (state == S_WB_REL) begin
            writebacks_q <= writebacks_q + 32'd1;
         end
         if (busy) begin
            busy_cycles_q <= busy_cycles_q + 32'd1;
         end
      end
   end

   assign perf_refills     = refills_q;
   assign perf_writebacks  = writebacks_q;
   assign perf_busy_cycles = busy_cycles_q;
`else
   assign perf_refills     = '0;
   assign perf_writebacks  = '0;
   assign perf_busy_cycles = '0;
`endif

endmodule

// File: tb/tb_cache_line_xfer.sv
// tb_cache_line_xfer
// Purpose : directed self-checking bench for cache_line_xfer with a small bus-controller/FIFO model.
// Latency : model accepts after acc_dly request cycles and raises ctl_done done_dly cycles later.
// Backpressure: stimulus holds resp_ready low for a chosen number of cycles before each handshake.

module tb_cache_line_xfer;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [63:0]   req_addr;
   logic          req_dirty;
   logic [63:0]   req_victim_addr;
   logic [511:0]  req_victim_data;
   logic          resp_valid;
   logic          resp_ready;
   logic [511:0]  resp_data;
   logic          busy;
   logic          ctl_ready;
   logic          ctl_req;
   logic          ctl_rw;
   logic [63:0]   ctl_addr;
   logic [63:0]   ctl_data;
   logic [7:0]    ctl_len;
   logic          ctl_done;
   logic [8:0]    fifo_idx;
   logic [63:0]   fifo_wdata;
   logic          fifo_wen;
   logic          fifo_done;
   logic [63:0]   fifo_rdata;
   logic [31:0]   perf_refills;
   logic [31:0]   perf_writebacks;
   logic [31:0]   perf_busy_cycles;

   always #5 clk = ~clk;

   cache_line_xfer dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_addr         (req_addr),
      .req_dirty        (req_dirty),
      .req_victim_addr  (req_victim_addr),
      .req_victim_data  (req_victim_data),
      .resp_valid       (resp_valid),
      .resp_ready       (resp_ready),
      .resp_data        (resp_data),
      .busy             (busy),
      .ctl_ready        (ctl_ready),
      .ctl_req          (ctl_req),
      .ctl_rw           (ctl_rw),
      .ctl_addr         (ctl_addr),
      .ctl_data         (ctl_data),
      .ctl_len          (ctl_len),
      .ctl_done         (ctl_done),
      .fifo_idx         (fifo_idx),
      .fifo_wdata       (fifo_wdata),
      .fifo_wen         (fifo_wen),
      .fifo_done        (fifo_done),
      .fifo_rdata       (fifo_rdata),
      .perf_refills     (perf_refills),
      .perf_writebacks  (perf_writebacks),
      .perf_busy_cycles (perf_busy_cycles)
   );

   // ---------------- checking ----------------
   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // ---------------- controller FIFO model ----------------
   logic [63:0] rd_beats [8];
   logic [63:0] exp_victim [8];

   always_comb begin
      fifo_rdata = 64'h0;
      for (int k = 0; k < 8; k++) begin
         if (fifo_idx == 9'(k * 64)) fifo_rdata = rd_beats[k];
      end
   end

   function automatic logic [511:0] line_of(input logic [63:0] base);
      logic [511:0] l;
      for (int k = 0; k < 8; k++) l[k*64 +: 64] = base * 64'(k + 1);
      return l;
   endfunction

   task automatic fill_rd(input logic [63:0] base);
      for (int k = 0; k < 8; k++) rd_beats[k] = base * 64'(k + 1);
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int acc_dly  = 0;
   int done_dly = 0;
   int m_st = 0, m_cnt = 0, m_beats = 0;
   logic m_wr = 1'b0;

   int wen_total = 0, wen_err = 0, run_err = 0, run_len = 0;
   int fdone_total = 0, order_err = 0, early_wen = 0, req_drop = 0, busy_cnt = 0;
   logic wr_pending = 1'b0, prev_wen = 1'b0;
   logic [63:0] last_rd_addr = '0, last_wr_addr = '0;

   initial begin
      ctl_ready = 1'b1;
      ctl_done  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_st = 0; ctl_ready = 1'b1; ctl_done = 1'b0;
            wr_pending = 1'b0; prev_wen = 1'b0; run_len = 0; busy_cnt = 0;
         end else begin
            // observe DUT
            if (busy) busy_cnt++;
            if (fifo_wen) begin
               if (!prev_wen) run_len = 0;
               if (run_len > 7) wen_err++;
               else if (fifo_idx !== 9'(run_len * 64) || fifo_wdata !== exp_victim[run_len]) wen_err++;
               if (m_st < 2) early_wen++;
               run_len++;
               wen_total++;
            end else if (prev_wen && run_len != 8) begin
               run_err++;
            end
            prev_wen = fifo_wen;
            if (fifo_done) fdone_total++;
            if (ctl_req && ctl_rw) begin
               wr_pending = 1'b1;
               last_wr_addr = ctl_addr;
            end
            if (ctl_req && !ctl_rw) begin
               if (wr_pending) order_err++;
               last_rd_addr = ctl_addr;
            end
            if (fifo_done) wr_pending = 1'b0;
            if (m_st != 0 && !ctl_req && !fifo_done) req_drop++;

            // respond as the controller
            if (m_st == 0 && ctl_req) begin
               m_wr = ctl_rw; m_cnt = acc_dly; m_beats = 0; m_st = 1;
            end
            if (m_st == 1) begin
               if (m_cnt == 0) begin
                  ctl_ready = 1'b0; m_cnt = done_dly; m_st = 2;
               end else m_cnt--;
            end else if (m_st == 2) begin
               if (m_wr && m_beats < 8) begin
                  if (fifo_wen) m_beats++;
               end else if (m_cnt == 0) begin
                  ctl_done = 1'b1; m_st = 3;
               end else m_cnt--;
            end else if (m_st == 3) begin
               if (fifo_done) begin
                  ctl_done = 1'b0; ctl_ready = 1'b1; m_st = 0;
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   int acc_cyc = 0;
   logic [511:0] got_line;

   task automatic set_req(input logic [63:0] addr, input logic dirty,
                          input logic [63:0] vaddr, input logic [63:0] vbase);
      for (int k = 0; k < 8; k++) begin
         exp_victim[k] = vbase + 64'(k);
         req_victim_data[k*64 +: 64] = vbase + 64'(k);
      end
      req_addr = addr;
      req_dirty = dirty;
      req_victim_addr = vaddr;
   endtask

   task automatic issue(input logic [63:0] addr, input logic dirty,
                        input logic [63:0] vaddr, input logic [63:0] vbase);
      int t;
      set_req(addr, dirty, vaddr, vbase);
      req_valid = 1'b1;
      t = 0;
      while (!req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("accept", 512'(req_ready), 512'(1'b1));
      acc_cyc = cyc;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_resp();
      int t;
      t = 0;
      while (!resp_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("resp_valid_seen", 512'(resp_valid), 512'(1'b1));
   endtask

   task automatic collect(input int hold, input logic [63:0] rbase, input int exp_lat);
      wait_resp();
      if (exp_lat > 0) check("latency", 512'(cyc - acc_cyc), 512'(exp_lat));
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", 512'(resp_valid), 512'(1'b1));
         check("hold_data", resp_data, line_of(rbase));
         @(negedge clk);
      end
      got_line = resp_data;
      check("resp_data", resp_data, line_of(rbase));
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("idle_after_resp", 512'({req_ready, resp_valid, busy}), 512'(3'b100));
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_flags"}, 512'({req_ready, busy, resp_valid, ctl_req, ctl_rw, fifo_wen, fifo_done}),
            512'(7'b1000000));
      check({tag, "_ctl_len"}, 512'(ctl_len), 512'(8'd7));
      check({tag, "_ctl_addr_data"}, 512'({ctl_addr, ctl_data}), '0);
      check({tag, "_fifo"}, 512'({fifo_idx, fifo_wdata}), '0);
      check({tag, "_resp_data"}, resp_data, '0);
      check({tag, "_perf"}, 512'({perf_refills, perf_writebacks, perf_busy_cycles}), '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   int wen0, err0, run0, fd0, ord0, early0, drop0, t;

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_addr = '0; req_dirty = 1'b0;
      req_victim_addr = '0; req_victim_data = '0; resp_ready = 1'b0;
      fill_rd(64'h0);
      for (int k = 0; k < 8; k++) exp_victim[k] = '0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      @(negedge clk);

      // clean miss, resp held 3 cycles
      wen0 = wen_total; fd0 = fdone_total;
      fill_rd(64'h11);
      issue(64'h8000_1043, 1'b0, 64'h0, 64'h0);
      collect(3, 64'h11, 12);
      check("clean_beat0", 512'(got_line[63:0]), 512'(64'h11));
      check("clean_beat7", 512'(got_line[511:448]), 512'(64'h88));
      check("clean_rd_addr", 512'(last_rd_addr), 512'(64'h8000_1040));
      check("clean_no_wen", 512'(wen_total - wen0), '0);
      check("clean_one_done", 512'(fdone_total - fd0), 512'(1));

      // dirty miss
      wen0 = wen_total; err0 = wen_err; run0 = run_err; fd0 = fdone_total; ord0 = order_err;
      fill_rd(64'h0101_0101_0101_0101);
      issue(64'h8000_3008, 1'b1, 64'h8000_2000, 64'hA0);
      collect(1, 64'h0101_0101_0101_0101, 0);
      check("dirty_wen_beats", 512'(wen_total - wen0), 512'(8));
      check("dirty_wen_data", 512'(wen_err - err0), '0);
      check("dirty_wen_consec", 512'(run_err - run0), '0);
      check("dirty_wr_addr", 512'(last_wr_addr), 512'(64'h8000_2000));
      check("dirty_rd_addr", 512'(last_rd_addr), 512'(64'h8000_3000));
      check("dirty_two_done", 512'(fdone_total - fd0), 512'(2));
      check("dirty_order", 512'(order_err - ord0), '0);

      // slow controller
      acc_dly = 5; done_dly = 20;
      wen0 = wen_total; err0 = wen_err; early0 = early_wen; drop0 = req_drop;
      fill_rd(64'h0000_0F00_0000_0003);
      issue(64'h8000_5000, 1'b1, 64'h8000_4025, 64'h7700);
      collect(2, 64'h0000_0F00_0000_0003, 0);
      check("slow_no_early_wen", 512'(early_wen - early0), '0);
      check("slow_req_held", 512'(req_drop - drop0), '0);
      check("slow_wen_beats", 512'(wen_total - wen0), 512'(8));
      check("slow_wen_data", 512'(wen_err - err0), '0);
      check("slow_wr_addr", 512'(last_wr_addr), 512'(64'h8000_4000));
      acc_dly = 0; done_dly = 0;

      // back-to-back: second request already valid in the handshake cycle
      fd0 = fdone_total; wen0 = wen_total;
      fill_rd(64'h2);
      issue(64'h8000_6000, 1'b0, 64'h0, 64'h0);
      wait_resp();
      check("b2b_first_data", resp_data, line_of(64'h2));
      set_req(64'h8000_7000, 1'b1, 64'h8000_8000, 64'h55);
      req_valid = 1'b1;
      resp_ready = 1'b1;
      check("b2b_ready_in_resp", 512'(req_ready), '0);
      @(negedge clk);
      resp_ready = 1'b0;
      check("b2b_ready_next", 512'({req_ready, resp_valid}), 512'(2'b10));
      check("b2b_first_done", 512'(fdone_total - fd0), 512'(1));
      fill_rd(64'h3);
      acc_cyc = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      check("b2b_accepted", 512'({busy, req_ready}), 512'(2'b10));
      collect(1, 64'h3, 0);
      check("b2b_done_per_burst", 512'(fdone_total - fd0), 512'(3));
      check("b2b_wen_beats", 512'(wen_total - wen0), 512'(8));

      // reset during W_FILL right after beat 3
      issue(64'h8000_9000, 1'b1, 64'h8000_A000, 64'hB0);
      t = 0;
      while (!(fifo_wen && fifo_idx == 9'd192) && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("midrst_at_beat3", 512'({fifo_wen, fifo_idx}), 512'({1'b1, 9'd192}));
      rst = 1'b1;
      @(negedge clk);
      check_reset("midrst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // fresh clean miss, then a dirty miss (also the perf scenario)
      fill_rd(64'h0000_0000_0123_4567);
      issue(64'h8000_B010, 1'b0, 64'h0, 64'h0);
      collect(0, 64'h0000_0000_0123_4567, 12);
      check("post_rst_rd_addr", 512'(last_rd_addr), 512'(64'h8000_B000));
      err0 = wen_err; run0 = run_err;
      fill_rd(64'h9);
      issue(64'h8000_C000, 1'b1, 64'h8000_D000, 64'hC0);
      collect(0, 64'h9, 0);
      check("post_rst_wen_data", 512'({wen_err - err0, run_err - run0}), '0);
      check("busy_cycles_counted", 512'(busy_cnt), 512'(35));
`ifdef LINE_XFER_PERF_EN
      check("perf_writebacks", 512'(perf_writebacks), 512'(1));
      check("perf_refills", 512'(perf_refills), 512'(2));
      check("perf_busy_cycles", 512'(perf_busy_cycles), 512'(busy_cnt));
`else
      check("perf_tied_off", 512'({perf_refills, perf_writebacks, perf_busy_cycles}), '0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
